// File: rtl/mdu_unit_pkg.sv
// Shared op codes and FSM state encodings for the multiply/divide unit.
package mdu_unit_pkg;

  localparam int MDU_OP_LEN = 3;

  localparam logic [MDU_OP_LEN-1:0] MDU_MULT  = 3'b000;
  localparam logic [MDU_OP_LEN-1:0] MDU_MULTU = 3'b001;
  localparam logic [MDU_OP_LEN-1:0] MDU_DIV   = 3'b010;
  localparam logic [MDU_OP_LEN-1:0] MDU_DIVU  = 3'b011;
  localparam logic [MDU_OP_LEN-1:0] MDU_MTHI  = 3'b100;
  localparam logic [MDU_OP_LEN-1:0] MDU_MTLO  = 3'b101;

  typedef enum logic [2:0] {
    MDU_S_IDLE = 3'd0,
    MDU_S_MUL  = 3'd1,
    MDU_S_DIV  = 3'd2,
    MDU_S_FIX  = 3'd3,
    MDU_S_DONE = 3'd4
  } mdu_state_e;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module mdu_divstep #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] divisor,
  input  logic              next_bit,
  output logic [DATA_W-1:0] new_rem,
  output logic              q_bit
);

  logic [DATA_W+1:0] diff;

  // rem < divisor on entry, so the shifted value always fits back in DATA_W bits
  always_comb begin
    diff    = {1'b0, rem, next_bit} - {2'b00, divisor};
    q_bit   = ~diff[DATA_W+1];
    new_rem = q_bit ? diff[DATA_W-1:0] : {rem[DATA_W-2:0], next_bit};
  end

endmodule

// File: rtl/mdu_unit.sv
// Iterative multiply/divide unit holding the HI/LO registers.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiply.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [MDU_OP_LEN-1:0] op,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic                  div0,
  output logic [DATA_W-1:0]     hi,
  output logic [DATA_W-1:0]     lo
);

  mdu_state_e          state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opb;
  logic                is_div;
  logic                neg_q;
  logic                neg_r;

  logic                signed_op;
  logic                a_neg;
  logic                b_neg;
  logic                res_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W-1:0]   step_rem;
  logic                step_q;
  logic                last_iter;

  // Operand magnitudes and result signs are captured when a request is accepted
  always_comb begin
    signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    a_neg     = signed_op & a[DATA_W-1];
    b_neg     = signed_op & b[DATA_W-1];
    res_neg   = a_neg ^ b_neg;
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opb} : '0);
    last_iter = (cnt == CNT_W'(DATA_W - 1));
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_mag;
  logic [2*DATA_W-1:0] fast_prod;

  always_comb begin
    fast_mag  = {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
    fast_prod = res_neg ? -fast_mag : fast_mag;
  end
`endif

  // acc holds {remainder, dividend/quotient} during division
  mdu_divstep #(.DATA_W(DATA_W)) u_divstep (
    .rem     (acc[2*DATA_W-1:DATA_W]),
    .divisor (opb),
    .next_bit(acc[DATA_W-1]),
    .new_rem (step_rem),
    .q_bit   (step_q)
  );

  // DONE accepts a new request exactly like IDLE so back-to-back ops lose no cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MDU_S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_S_IDLE, MDU_S_DONE: begin
          state <= MDU_S_IDLE;
          if (start) begin
            case (op)
              MDU_MTHI: hi <= a;
              MDU_MTLO: lo <= a;
              MDU_MULT, MDU_MULTU: begin
                div0 <= 1'b0;
`ifdef MDU_FAST_MUL_EN
                {hi, lo} <= fast_prod;
                done     <= 1'b1;
                state    <= MDU_S_DONE;
`else
                acc    <= {{DATA_W{1'b0}}, a_mag};
                opb    <= b_mag;
                neg_q  <= res_neg;
                is_div <= 1'b0;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= MDU_S_MUL;
`endif
              end
              MDU_DIV, MDU_DIVU: begin
                if (b == '0) begin
                  hi    <= a;
                  lo    <= '1;
                  div0  <= 1'b1;
                  done  <= 1'b1;
                  state <= MDU_S_DONE;
                end else begin
                  div0   <= 1'b0;
                  acc    <= {{DATA_W{1'b0}}, a_mag};
                  opb    <= b_mag;
                  neg_q  <= res_neg;
                  neg_r  <= a_neg;
                  is_div <= 1'b1;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= MDU_S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        MDU_S_MUL: begin
          acc <= {mul_sum, acc[DATA_W-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (last_iter) state <= MDU_S_FIX;
        end
        MDU_S_DIV: begin
          acc <= {step_rem, acc[DATA_W-2:0], step_q};
          cnt <= cnt + CNT_W'(1);
          if (last_iter) state <= MDU_S_FIX;
        end
        MDU_S_FIX: begin
          if (is_div) begin
            hi <= neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
            lo <= neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
          end else begin
            {hi, lo} <= neg_q ? -acc : acc;
          end
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= MDU_S_DONE;
        end
        default: state <= MDU_S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit (default iterative-multiply build).
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  mdu_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .div0 (div0),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a one-cycle start; returns at the negedge of cycle 1 after acceptance
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'hDEAD_BEEF;
  endtask

  // Counts cycles (current cycle = 1) until done; -1 on timeout
  task automatic run_until_done(output int cycles, output int busy_cycles);
    cycles      = -1;
    busy_cycles = 0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        cycles = k;
        return;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op    = MDU_MULTU;
    a     = '0;
    b     = '0;
    #12;
    checks += 5;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    if (div0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_div0 got=%b exp=0", div0); end
    if (hi !== 32'h0) begin failures++; $display("[TB] FAIL reset_hi got=%h exp=0", hi); end
    if (lo !== 32'h0) begin failures++; $display("[TB] FAIL reset_lo got=%h exp=0", lo); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu();
    int cyc, bcyc;
    applyStimulus(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_until_done(cyc, bcyc);
    checks += 5;
    if (cyc != 34) begin failures++; $display("[TB] FAIL multu_latency got=%0d exp=34", cyc); end
    if (bcyc != 33) begin failures++; $display("[TB] FAIL multu_busy_cycles got=%0d exp=33", bcyc); end
    if (hi !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL multu_hi got=%h exp=fffffffe", hi); end
    if (lo !== 32'h0000_0001) begin failures++; $display("[TB] FAIL multu_lo got=%h exp=00000001", lo); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL multu_busy_at_done got=%b exp=0", busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL multu_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_mult();
    int cyc, bcyc;
    applyStimulus(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
    run_until_done(cyc, bcyc);
    checks += 3;
    if (cyc != 34) begin failures++; $display("[TB] FAIL mult_latency got=%0d exp=34", cyc); end
    if (hi !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mult_hi got=%h exp=ffffffff", hi); end
    if (lo !== 32'hFFFF_FFEB) begin failures++; $display("[TB] FAIL mult_lo got=%h exp=ffffffeb", lo); end
  endtask

  task automatic test_div();
    int cyc, bcyc;
    applyStimulus(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    run_until_done(cyc, bcyc);
    checks += 3;
    if (cyc != 34) begin failures++; $display("[TB] FAIL div_latency got=%0d exp=34", cyc); end
    if (lo !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_lo got=%h exp=fffffffd", lo); end
    if (hi !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div_hi got=%h exp=ffffffff", hi); end
    applyStimulus(MDU_DIVU, 32'd7, 32'd2);
    run_until_done(cyc, bcyc);
    checks += 2;
    if (lo !== 32'd3) begin failures++; $display("[TB] FAIL divu_lo got=%h exp=3", lo); end
    if (hi !== 32'd1) begin failures++; $display("[TB] FAIL divu_hi got=%h exp=1", hi); end
    applyStimulus(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_until_done(cyc, bcyc);
    checks += 3;
    if (lo !== 32'h8000_0000) begin failures++; $display("[TB] FAIL div_ovf_lo got=%h exp=80000000", lo); end
    if (hi !== 32'h0) begin failures++; $display("[TB] FAIL div_ovf_hi got=%h exp=0", hi); end
    if (div0 !== 1'b0) begin failures++; $display("[TB] FAIL div_ovf_div0 got=%b exp=0", div0); end
  endtask

  task automatic test_div_zero();
    int cyc, bcyc;
    applyStimulus(MDU_DIV, 32'h0000_1234, 32'h0);
    checks += 5;
    if (done !== 1'b1) begin failures++; $display("[TB] FAIL div0_done got=%b exp=1", done); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL div0_busy got=%b exp=0", busy); end
    if (div0 !== 1'b1) begin failures++; $display("[TB] FAIL div0_flag got=%b exp=1", div0); end
    if (hi !== 32'h0000_1234) begin failures++; $display("[TB] FAIL div0_hi got=%h exp=00001234", hi); end
    if (lo !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div0_lo got=%h exp=ffffffff", lo); end
    @(negedge clk);
    checks++;
    if (div0 !== 1'b1) begin failures++; $display("[TB] FAIL div0_sticky got=%b exp=1", div0); end
    applyStimulus(MDU_MULTU, 32'd3, 32'd5);
    checks++;
    if (div0 !== 1'b0) begin failures++; $display("[TB] FAIL div0_clear got=%b exp=0", div0); end
    run_until_done(cyc, bcyc);
    checks += 2;
    if (lo !== 32'd15) begin failures++; $display("[TB] FAIL div0_next_lo got=%h exp=f", lo); end
    if (hi !== 32'd0) begin failures++; $display("[TB] FAIL div0_next_hi got=%h exp=0", hi); end
  endtask

  task automatic test_mthi_mtlo();
    int cyc, bcyc;
    applyStimulus(MDU_MTHI, 32'hAAAA_5555, 32'h0);
    checks += 3;
    if (hi !== 32'hAAAA_5555) begin failures++; $display("[TB] FAIL mthi_hi got=%h exp=aaaa5555", hi); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mthi_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL mthi_done got=%b exp=0", done); end
    applyStimulus(MDU_MTLO, 32'h5555_AAAA, 32'h0);
    checks += 4;
    if (lo !== 32'h5555_AAAA) begin failures++; $display("[TB] FAIL mtlo_lo got=%h exp=5555aaaa", lo); end
    if (hi !== 32'hAAAA_5555) begin failures++; $display("[TB] FAIL mtlo_hi_kept got=%h exp=aaaa5555", hi); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mtlo_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL mtlo_done got=%b exp=0", done); end
    // A start raised mid-operation must be dropped
    applyStimulus(MDU_MULTU, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    checks += 2;
    if (hi !== 32'hAAAA_5555) begin failures++; $display("[TB] FAIL busy_hi_held got=%h exp=aaaa5555", hi); end
    if (lo !== 32'h5555_AAAA) begin failures++; $display("[TB] FAIL busy_lo_held got=%h exp=5555aaaa", lo); end
    start = 1'b1;
    op    = MDU_MULTU;
    a     = 32'hFFFF_FFFF;
    b     = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    run_until_done(cyc, bcyc);
    checks += 3;
    if (cyc != 29) begin failures++; $display("[TB] FAIL busy_ignore_latency got=%0d exp=29", cyc); end
    if (lo !== 32'd42) begin failures++; $display("[TB] FAIL busy_ignore_lo got=%h exp=2a", lo); end
    if (hi !== 32'd0) begin failures++; $display("[TB] FAIL busy_ignore_hi got=%h exp=0", hi); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_ignore_idle got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    applyStimulus(MDU_MULTU, 32'd9, 32'd9);
    run_until_done(cyc, bcyc);
    start = 1'b1;
    op    = MDU_DIVU;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    checks += 2;
    if (lo !== 32'd81) begin failures++; $display("[TB] FAIL b2b_first_lo got=%h exp=51", lo); end
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_accept_busy got=%b exp=1", busy); end
    run_until_done(cyc, bcyc);
    checks += 3;
    if (cyc != 34) begin failures++; $display("[TB] FAIL b2b_latency got=%0d exp=34", cyc); end
    if (lo !== 32'd14) begin failures++; $display("[TB] FAIL b2b_lo got=%h exp=e", lo); end
    if (hi !== 32'd2) begin failures++; $display("[TB] FAIL b2b_hi got=%h exp=2", hi); end
  endtask

  task automatic test_reset_mid();
    int cyc, bcyc;
    applyStimulus(MDU_DIVU, 32'hFFFF_0000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
    if (hi !== 32'h0) begin failures++; $display("[TB] FAIL midrst_hi got=%h exp=0", hi); end
    if (lo !== 32'h0) begin failures++; $display("[TB] FAIL midrst_lo got=%h exp=0", lo); end
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done got=%b exp=0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(MDU_DIVU, 32'd100, 32'd9);
    run_until_done(cyc, bcyc);
    checks += 3;
    if (cyc != 34) begin failures++; $display("[TB] FAIL midrst_next_latency got=%0d exp=34", cyc); end
    if (lo !== 32'd11) begin failures++; $display("[TB] FAIL midrst_next_lo got=%h exp=b", lo); end
    if (hi !== 32'd1) begin failures++; $display("[TB] FAIL midrst_next_hi got=%h exp=1", hi); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
